// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size encodings, FSM states,
// the latched request payload and the alignment check.
package lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OFFS_W = 2;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Request fields held for the duration of one transaction.
    typedef struct packed {
        logic              we;
        size_e             size;
        logic              is_unsigned;
        logic [OFFS_W-1:0] offs;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // True for the reserved size and for halves/words not on their natural boundary.
    function automatic logic misaligned(input size_e size, input logic [OFFS_W-1:0] offs);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = offs[0];
            SZ_W:    bad = (offs != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit.
//   i_size, i_offs     access size and byte offset within the word
//   i_unsigned         zero-extend (1) or sign-extend (0) loads
//   i_word             word read from data memory
//   i_wdata            right-justified store data
//   o_extract_data     selected lane, extended to 32 bits
//   o_merge_data       i_word with the store lane replaced (word size: i_wdata)
module lsu_lane_align
    import lsu_pkg::*;
(
    input  size_e              i_size,
    input  logic [OFFS_W-1:0]  i_offs,
    input  logic               i_unsigned,
    input  logic [DATA_W-1:0]  i_word,
    input  logic [DATA_W-1:0]  i_wdata,
    output logic [DATA_W-1:0]  o_extract_data,
    output logic [DATA_W-1:0]  o_merge_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian lane extraction and extension.
    always_comb begin
        w_byte         = i_word[{i_offs, 3'b000} +: 8];
        w_half         = i_word[{i_offs[1], 4'b0000} +: 16];
        o_extract_data = i_word;
        case (i_size)
            SZ_B: o_extract_data = i_unsigned ? {24'h0, w_byte}
                                              : {{24{w_byte[7]}}, w_byte};
            SZ_H: o_extract_data = i_unsigned ? {16'h0, w_half}
                                              : {{16{w_half[15]}}, w_half};
            default: o_extract_data = i_word;
        endcase
    end

    // Read-modify-write merge; untouched bytes keep the memory value.
    always_comb begin
        o_merge_data = i_word;
        case (i_size)
            SZ_B:    o_merge_data[{i_offs, 3'b000} +: 8]     = i_wdata[7:0];
            SZ_H:    o_merge_data[{i_offs[1], 4'b0000} +: 16] = i_wdata[15:0];
            default: o_merge_data = i_wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage front end: byte/half/word loads and stores against a
// word-only data memory, one request in flight at a time.
//   clk, rst                  clock, async active-high reset
//   req_*                     request channel from execute (valid/ready)
//   resp_*                    response channel to writeback (valid/ready)
//   dm_addr/dm_mw/dm_wdata    word address, write enable, write word to memory
//   dm_rdata                  combinational read word from memory
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-3:0]   dm_addr,
    output logic                dm_mw,
    output logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W-1:0]   dm_rdata
);

    localparam int unsigned WADDR_W = ADDR_W - 2;

    state_e               r_state;
    state_e               w_next_state;
    req_t                 r_req;
    logic [WADDR_W-1:0]   r_dm_addr;
    logic [DATA_W-1:0]    r_merge;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_err;
    logic                 w_store_word;
    logic [DATA_W-1:0]    w_extract;
    logic [DATA_W-1:0]    w_merge;

    assign w_accept     = req_valid & req_ready;
    assign w_err        = misaligned(r_req.size, r_req.offs);
    assign w_store_word = r_req.we & (r_req.size == SZ_W) & ~w_err;

    lsu_lane_align u_lane_align (
        .i_size         (r_req.size),
        .i_offs         (r_req.offs),
        .i_unsigned     (r_req.is_unsigned),
        .i_word         (dm_rdata),
        .i_wdata        (r_req.wdata),
        .o_extract_data (w_extract),
        .o_merge_data   (w_merge)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic; errors, loads and word stores skip WRITE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next_state = ST_ACCESS;
            ST_ACCESS: begin
                if (w_err || !r_req.we || r_req.size == SZ_W) w_next_state = ST_RESP;
                else                                          w_next_state = ST_WRITE;
            end
            ST_WRITE:  w_next_state = ST_RESP;
            ST_RESP:   if (resp_ready) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Request latch and response/merge registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req     <= '0;
            r_dm_addr <= '0;
            r_merge   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_req.we          <= req_we;
                r_req.size        <= size_e'(req_size);
                r_req.is_unsigned <= req_unsigned;
                r_req.offs        <= req_addr[1:0];
                r_req.wdata       <= req_wdata;
                r_dm_addr         <= req_addr[ADDR_W-1:2];
                r_rdata           <= '0;
                r_err             <= 1'b0;
            end
            if (r_state == ST_ACCESS) begin
                r_err   <= w_err;
                r_rdata <= (!w_err && !r_req.we) ? w_extract : '0;
                r_merge <= w_merge;
            end
        end
    end

    // State-decoded outputs; dm_mw falls with the state on reset.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        dm_mw      = 1'b0;
        dm_wdata   = '0;
        case (r_state)
            ST_IDLE:   req_ready = 1'b1;
            ST_ACCESS: if (w_store_word) begin
                dm_mw    = 1'b1;
                dm_wdata = r_req.wdata;
            end
            ST_WRITE: begin
                dm_mw    = 1'b1;
                dm_wdata = r_merge;
            end
            ST_RESP:   resp_valid = 1'b1;
            default:   req_ready = 1'b0;
        endcase
    end

    assign dm_addr    = r_dm_addr;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with a behavioural data memory and a byte-level
// reference model of memory contents and responses.
module tb_load_store_unit;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned WORDS  = 16384;

    logic                clk = 1'b0;
    logic                rst;
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [1:0]          req_size;
    logic                req_unsigned;
    logic [ADDR_W-1:0]   req_addr;
    logic [31:0]         req_wdata;
    logic                resp_valid;
    logic                resp_ready;
    logic [31:0]         resp_rdata;
    logic                resp_err;
    logic [ADDR_W-3:0]   dm_addr;
    logic                dm_mw;
    logic [31:0]         dm_wdata;
    logic [31:0]         dm_rdata;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .dm_addr      (dm_addr),
        .dm_mw        (dm_mw),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata)
    );

    always #5 clk = ~clk;

    // data_memory stand-in: combinational read, word write on posedge.
    logic [31:0] mem     [0:WORDS-1];
    logic [31:0] ref_mem [0:WORDS-1];
    logic        mem_init;

    assign dm_rdata = mem[dm_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= (i < 256) ? 32'(i) : 32'h0;
        end else if (dm_mw) begin
            mem[dm_addr] <= dm_wdata;
        end
    end

    int mw_cnt = 0;
    always @(posedge clk) if (dm_mw === 1'b1) mw_cnt <= mw_cnt + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed semantics applied to ref_mem.
    task automatic ref_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [15:0] addr, input logic [31:0] wdata,
                          output logic [31:0] e_rdata, output logic e_err,
                          output int e_lat, output int e_mw);
        int          off;
        int          widx;
        int          nb;
        logic [31:0] mask;
        logic [31:0] v;
        off  = int'(addr % 16'd4);
        widx = int'(addr >> 2);
        nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        e_err   = (size == 2'd3) || (size == 2'd1 && (off % 2) != 0) || (size == 2'd2 && off != 0);
        e_rdata = 32'h0;
        e_mw    = 0;
        e_lat   = 2;
        if (!e_err) begin
            if (!we) begin
                mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
                v    = (ref_mem[widx] >> (8 * off)) & mask;
                if (!uns && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
                e_rdata = v;
            end else begin
                for (int b = 0; b < nb; b++)
                    ref_mem[widx][8 * (off + b) +: 8] = wdata[8 * b +: 8];
                e_mw  = 1;
                e_lat = (nb == 4) ? 2 : 3;
            end
        end
    endtask

    // One full transaction with resp_ready held high, checked against the model.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [15:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
        int          e_mw;
        int          lat;
        int          mw0;
        int          widx;
        ref_op(we, size, uns, addr, wdata, e_rdata, e_err, e_lat, e_mw);
        widx         = int'(addr >> 2);
        mw0          = mw_cnt;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        resp_ready   = 1'b1;
        check_eq("req_ready_idle", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(e_lat));
        rdata = resp_rdata;
        err   = resp_err;
        check_eq("rdata", rdata, e_rdata);
        check_eq("err", 32'(err), 32'(e_err));
        @(posedge clk); #1;
        check_eq("mw_pulses", 32'(mw_cnt - mw0), 32'(e_mw));
        check_eq("mem_word", mem[widx], ref_mem[widx]);
        check_eq("resp_valid_after", 32'(resp_valid), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] held;
        int          mw0;
        int          lat;

        for (int i = 0; i < WORDS; i++) ref_mem[i] = (i < 256) ? 32'(i) : 32'h0;
        rst          = 1'b1;
        mem_init     = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        resp_ready   = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state.
        check_eq("rst_req_ready", 32'(req_ready), 32'h1);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
        check_eq("rst_resp_err", 32'(resp_err), 32'h0);
        check_eq("rst_resp_rdata", resp_rdata, 32'h0);
        check_eq("rst_dm_mw", 32'(dm_mw), 32'h0);
        check_eq("rst_dm_addr", 32'(dm_addr), 32'h0);
        check_eq("rst_dm_wdata", dm_wdata, 32'h0);
        mem_init = 1'b0;
        rst      = 1'b0;
        @(posedge clk); #1;

        // Word load.
        do_req(1'b0, 2'b10, 1'b0, 16'h0014, 32'h0, rd, er);
        check_eq("t1_rdata", rd, 32'h0000_0005);

        // Word store then sub-word loads.
        do_req(1'b1, 2'b10, 1'b0, 16'h0040, 32'hDEAD_BEEF, rd, er);
        do_req(1'b0, 2'b00, 1'b0, 16'h0043, 32'h0, rd, er);
        check_eq("t2_lb_signed", rd, 32'hFFFF_FFDE);
        do_req(1'b0, 2'b01, 1'b1, 16'h0042, 32'h0, rd, er);
        check_eq("t2_lhu", rd, 32'h0000_DEAD);

        // Byte store read-modify-write.
        do_req(1'b1, 2'b00, 1'b0, 16'h0041, 32'h0000_007A, rd, er);
        check_eq("t3_mem", mem[16], 32'hDEAD_7AEF);

        // Misaligned accesses.
        do_req(1'b0, 2'b01, 1'b0, 16'h0003, 32'h0, rd, er);
        check_eq("t4_half_err", 32'(er), 32'h1);
        check_eq("t4_half_rdata", rd, 32'h0);
        do_req(1'b1, 2'b10, 1'b0, 16'h0006, 32'hCAFE_F00D, rd, er);
        check_eq("t4_word_err", 32'(er), 32'h1);
        check_eq("t4_mem", mem[1], 32'h0000_0001);

        // Back-pressure in RESP, with a competing request that must be ignored.
        mw0          = mw_cnt;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 16'h0010;
        req_valid    = 1'b1;
        resp_ready   = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("t5_latency", 32'(lat), 32'd2);
        held      = resp_rdata;
        check_eq("t5_rdata", held, 32'h0000_0004);
        req_we    = 1'b1;
        req_addr  = 16'h0080;
        req_wdata = 32'h1234_5678;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("t5_hold_valid", 32'(resp_valid), 32'h1);
            check_eq("t5_hold_rdata", resp_rdata, 32'h0000_0004);
            check_eq("t5_hold_ready", 32'(req_ready), 32'h0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("t5_released", 32'(resp_valid), 32'h0);
        check_eq("t5_mem", mem[32], 32'h0000_0020);
        check_eq("t5_no_mw", 32'(mw_cnt - mw0), 32'h0);

        // Reset in the middle of a byte-store write-back.
        mw0          = mw_cnt;
        req_we       = 1'b1;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 16'h0050;
        req_wdata    = 32'h0000_0055;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("t6_in_write", 32'(dm_mw), 32'h1);
        rst = 1'b1;
        #1;
        check_eq("t6_mw_drop", 32'(dm_mw), 32'h0);
        check_eq("t6_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("t6_mem", mem[20], 32'h0000_0014);
        check_eq("t6_no_resp", 32'(resp_valid), 32'h0);
        check_eq("t6_no_mw", 32'(mw_cnt - mw0), 32'h0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   16'($urandom_range(0, 1023)), $urandom, rd, er);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
